mult_rr_sequencer: RTL



---
 rtl/mult_rr_sequencer_pkg.sv | 15 +
 rtl/Counter.sv | 18 +
 rtl/Data_Path.sv | 34 +++
 rtl/mult_rr_sequencer_arb.sv | 34 +++
 rtl/mult_rr_sequencer.sv | 107 ++++++++++
 5 files changed

// File: rtl/mult_rr_sequencer_pkg.sv
// mult_rr_sequencer_pkg: shared state encoding and widths for the multiplier sequencer.
// Rev 1.0
`default_nettype none

package mult_rr_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int REQ_ID_W = 1;
endpackage

`default_nettype wire

// File: rtl/Counter.sv
// Counter: free-running iteration counter with synchronous clear.
// Rev 1.0
`default_nettype none

module Counter #(
  parameter int CNT_SIZE = 5
) (
  input  logic                Clock,
  input  logic                iReset,
  output logic [CNT_SIZE-1:0] oCount
);
  always_ff @(posedge Clock) begin
    if (iReset) oCount <= '0;
    else        oCount <= oCount + 1'b1;
  end
endmodule

`default_nettype wire

// File: rtl/Data_Path.sv
// Data_Path: shift-add multiplier datapath; one partial-product step per clock while not loading.
// Rev 1.0
`default_nettype none

module Data_Path #(
  parameter int SIZE = 32
) (
  input  logic                Clock,
  input  logic                iData_Reset,
  input  logic [SIZE-1:0]     iData_A,
  input  logic [SIZE-1:0]     iData_B,
  output logic [2*SIZE-1:0]   oProduct
);
  logic [2*SIZE-1:0] mcand;
  logic [2*SIZE-1:0] acc;
  logic [SIZE-1:0]   mplier;

  // Once the multiplier has shifted down to zero no further adds occur, so acc holds.
  always_ff @(posedge Clock) begin
    if (iData_Reset) begin
      mcand  <= {{SIZE{1'b0}}, iData_A};
      mplier <= iData_B;
      acc    <= '0;
    end else begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

  assign oProduct = acc;
endmodule

`default_nettype wire

// File: rtl/mult_rr_sequencer_arb.sv
// rr_arbiter2: two-way round-robin grant with last-granted pointer.
// Rev 1.0
`default_nettype none

module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       accept,
  output logic [1:0] grant,
  output logic       grant_id
);
  logic last_id;

  // On a tie the requester that was not served last wins.
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_id ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  assign grant_id = grant[1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         last_id <= 1'b1;
    else if (accept) last_id <= grant_id;
  end
endmodule

`default_nettype wire

// File: rtl/mult_rr_sequencer.sv
// mult_rr_sequencer: arbitrates two multiply requesters onto one shift-add datapath.
// Rev 1.0
`default_nettype none

module mult_rr_sequencer
  import mult_rr_sequencer_pkg::*;
#(
  parameter int SIZE     = 32,
  parameter int CNT_SIZE = 5
) (
  input  logic              Clock,
  input  logic              iReset,
  input  logic [1:0]        iReq_Valid,
  output logic [1:0]        oReq_Ready,
  input  logic [SIZE-1:0]   iReq_A0,
  input  logic [SIZE-1:0]   iReq_B0,
  input  logic [SIZE-1:0]   iReq_A1,
  input  logic [SIZE-1:0]   iReq_B1,
  output logic              oRes_Valid,
  input  logic              iRes_Ready,
  output logic [2*SIZE-1:0] oRes_Product,
  output logic              oRes_Id,
  output logic              oBusy
);
  state_t                state;
  logic                  busy_q;
  logic                  valid_q;
  logic [REQ_ID_W-1:0]   id_q;
  logic [1:0]            grant;
  logic                  grant_id;
  logic                  in_idle;
  logic                  accept;
  logic                  last_iter;
  logic [SIZE-1:0]       op_a;
  logic [SIZE-1:0]       op_b;
  logic [2*SIZE-1:0]     product;
  logic [CNT_SIZE-1:0]   count;

  assign in_idle    = (state == IDLE);
  assign oReq_Ready = in_idle ? grant : 2'b00;
  assign accept     = |(iReq_Valid & oReq_Ready);
  assign op_a       = grant_id ? iReq_A1 : iReq_A0;
  assign op_b       = grant_id ? iReq_B1 : iReq_B0;
  assign last_iter  = (count == CNT_SIZE'(SIZE - 1));

  rr_arbiter2 u_arb (
    .clk      (Clock),
    .rst      (iReset),
    .req      (iReq_Valid),
    .accept   (accept),
    .grant    (grant),
    .grant_id (grant_id)
  );

  // The datapath reloads continuously while idle, so the accept edge captures the operands.
  Data_Path #(.SIZE(SIZE)) u_dp (
    .Clock       (Clock),
    .iData_Reset (in_idle),
    .iData_A     (op_a),
    .iData_B     (op_b),
    .oProduct    (product)
  );

  Counter #(.CNT_SIZE(CNT_SIZE)) u_cnt (
    .Clock  (Clock),
    .iReset (in_idle),
    .oCount (count)
  );

  always_ff @(posedge Clock or posedge iReset) begin
    if (iReset) begin
      state   <= IDLE;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      id_q    <= '0;
    end else begin
      case (state)
        IDLE: if (accept) begin
          state  <= RUN;
          busy_q <= 1'b1;
          id_q   <= grant_id;
        end
        RUN: if (last_iter) begin
          state   <= DONE;
          valid_q <= 1'b1;
        end
        DONE: if (iRes_Ready) begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign oRes_Valid   = valid_q;
  assign oRes_Product = valid_q ? product : '0;
  assign oRes_Id      = valid_q ? id_q : 1'b0;
  assign oBusy        = busy_q;
endmodule

`default_nettype wire
